// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix and key-report signal bundle
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] hex;
    logic       key_valid;
    logic       key_held;

    // Scanner side: senses rows, drives columns and the key report
    modport master (
        input  row,
        output col,
        output hex,
        output key_valid,
        output key_held
    );

    // Keypad / consumer side
    modport slave (
        output row,
        input  col,
        input  hex,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 active-low keypad scanner with debounce
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    keypad_scanner_if.master  kp
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t        state;
    logic [3:0]    row_m;
    logic [3:0]    row_s;
    logic [DW-1:0] div;
    logic          stb;
    logic [1:0]    col_idx;
    logic [CW-1:0] cnt;
    logic [1:0]    lat_row;
    logic [1:0]    cand_row;
    logic          any_low;
    logic          lat_low;
    logic [3:0]    hex;
    logic          key_valid;
    logic          key_held;

    // Hex code for the key at row r, column c
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Two-flop synchronizer for the asynchronous row inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_m <= 4'hF;
            row_s <= 4'hF;
        end else begin
            row_m <= kp.row;
            row_s <= row_m;
        end
    end

    // Free-running column dwell divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else begin
            div <= (div == DIV_LAST) ? '0 : div + 1'b1;
        end
    end

    assign stb = (div == DIV_LAST);

    // Lowest-index low row is the press candidate
    always_comb begin
        cand_row = 2'd3;
        if (!row_s[0])      cand_row = 2'd0;
        else if (!row_s[1]) cand_row = 2'd1;
        else if (!row_s[2]) cand_row = 2'd2;
        any_low = ~&row_s;
        lat_low = ~row_s[lat_row];
    end

    // Scan / debounce / hold / release sequencer with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            cnt       <= '0;
            lat_row   <= 2'd0;
            hex       <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (stb) begin
                case (state)
                    SCAN: begin
                        if (any_low) begin
                            lat_row <= cand_row;
                            if (DEBOUNCE_SCANS == 1) begin
                                hex       <= key_code(cand_row, col_idx);
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                state     <= HELD;
                            end else begin
                                cnt   <= CNT_ONE;
                                state <= DEBOUNCE;
                            end
                        end else begin
                            col_idx <= col_idx + 1'b1;
                        end
                    end
                    DEBOUNCE: begin
                        if (lat_low) begin
                            if (cnt == CNT_LAST) begin
                                hex       <= key_code(lat_row, col_idx);
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                state     <= HELD;
                            end
                            cnt <= cnt + 1'b1;
                        end else begin
                            state   <= SCAN;
                            col_idx <= col_idx + 1'b1;
                        end
                    end
                    HELD: begin
                        if (!lat_low) begin
                            if (DEBOUNCE_SCANS == 1) begin
                                key_held <= 1'b0;
                                state    <= SCAN;
                            end else begin
                                cnt   <= CNT_ONE;
                                state <= RELEASE;
                            end
                        end
                    end
                    RELEASE: begin
                        if (lat_low) begin
                            state <= HELD;
                        end else begin
                            if (cnt == CNT_LAST) begin
                                key_held <= 1'b0;
                                state    <= SCAN;
                            end
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

    assign kp.col       = ~(4'b0001 << col_idx);
    assign kp.hex       = hex;
    assign kp.key_valid = key_valid;
    assign kp.key_held  = key_held;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DS = 3;
    localparam int PRESS_LAT = (SD - 1) + (DS - 1) * SD + 1;
    localparam int REL_LAT   = DS * SD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    keypad_scanner_if kif();

    logic [15:0] pressed = '0;
    logic        force_en = 1'b0;
    logic [3:0]  force_row = 4'hF;
    logic [3:0]  row_kp;
    int checks = 0;
    int failures = 0;
    int kv_count = 0;
    int kv_wide = 0;
    logic kv_prev = 1'b0;
    int tdiv = 0;
    logic [3:0] last_hex = 4'h0;
    logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kif.master)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key pulls its row low while its column is driven
    always_comb begin
        row_kp = 4'hF;
        for (int i = 0; i < 16; i++)
            if (pressed[i] && !kif.col[i % 4]) row_kp[i / 4] = 1'b0;
    end
    assign kif.row = force_en ? force_row : row_kp;

    // Independent dwell counter: strobe precedes the edge where tdiv == SD-1
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tdiv <= 0;
        else        tdiv <= (tdiv == SD - 1) ? 0 : tdiv + 1;
    end

    // key_valid pulse counter and width monitor
    always @(negedge clk) begin
        if (kif.key_valid === 1'b1) begin
            kv_count <= kv_count + 1;
            if (kv_prev) kv_wide <= kv_wide + 1;
        end
        kv_prev <= kif.key_valid;
    end

    function automatic logic [3:0] colv(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << (c % 4));
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_stb();
        do tick(); while (tdiv != SD - 1);
        tick();
    endtask

    task automatic wait_col(input int c);
        int n;
        n = 0;
        while (kif.col !== colv(c) && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            checks++; failures++;
            $display("FAIL wait_col: col=%b never reached %b", kif.col, colv(c));
        end
    endtask

    task automatic do_press(input int r, input int c);
        int n;
        int kv0;
        wait_col((c + 1) % 4);
        pressed[r * 4 + c] = 1'b1;
        wait_col(c);
        kv0 = kv_count;
        n = 0;
        while (kif.key_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n != PRESS_LAT) begin
            failures++;
            $display("FAIL press_latency r%0d c%0d: got %0d cycles, want %0d", r, c, n, PRESS_LAT);
        end
        checks++;
        if (kif.hex !== keymap[r * 4 + c]) begin
            failures++;
            $display("FAIL press_hex r%0d c%0d: got %h, want %h", r, c, kif.hex, keymap[r * 4 + c]);
        end
        last_hex = keymap[r * 4 + c];
        checks++;
        if (kif.key_held !== 1'b1 || kif.col !== colv(c)) begin
            failures++;
            $display("FAIL press_held r%0d c%0d: held=%b col=%b, want held=1 col=%b", r, c, kif.key_held, kif.col, colv(c));
        end
        repeat (8) tick();
        checks++;
        if (kv_count != kv0 + 1 || kif.col !== colv(c) || kif.key_held !== 1'b1) begin
            failures++;
            $display("FAIL press_frozen r%0d c%0d: pulses=%0d col=%b held=%b, want 1 %b 1", r, c, kv_count - kv0, kif.col, colv(c), kif.key_held);
        end
    endtask

    task automatic do_release(input int r, input int c);
        int n;
        int kv0;
        wait_stb();
        kv0 = kv_count;
        pressed[r * 4 + c] = 1'b0;
        n = 0;
        while (kif.key_held === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n != REL_LAT) begin
            failures++;
            $display("FAIL release_latency r%0d c%0d: got %0d cycles, want %0d", r, c, n, REL_LAT);
        end
        repeat (SD) tick();
        checks++;
        if (kif.col !== colv(c + 1) || kv_count != kv0) begin
            failures++;
            $display("FAIL release_resume r%0d c%0d: col=%b pulses=%0d, want col=%b pulses=0", r, c, kif.col, kv_count - kv0, colv(c + 1));
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if (kif.col !== 4'b1110 || kif.hex !== 4'h0 || kif.key_valid !== 1'b0 || kif.key_held !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: col=%b hex=%h kv=%b held=%b, want 1110 0 0 0", kif.col, kif.hex, kif.key_valid, kif.key_held);
        end
        rst_n = 1'b1;
        repeat (5 + $urandom_range(0, 6)) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (kif.col !== 4'b1110 || kif.hex !== 4'h0 || kif.key_valid !== 1'b0 || kif.key_held !== 1'b0) begin
            failures++;
            $display("FAIL reset_midscan: col=%b hex=%h kv=%b held=%b, want 1110 0 0 0", kif.col, kif.hex, kif.key_valid, kif.key_held);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 17; k++) begin
            checks++;
            if (kif.col !== colv(k / SD)) begin
                failures++;
                $display("FAIL col_step k=%0d: got %b, want %b", k, kif.col, colv(k / SD));
            end
            tick();
        end
    endtask

    task automatic test_clean_press();
        do_press(2, 1);
        do_release(2, 1);
    endtask

    task automatic test_map_corners();
        int rs [6] = '{0, 0, 3, 3, 3, 3};
        int cs [6] = '{0, 3, 0, 1, 2, 3};
        for (int i = 0; i < 6; i++) begin
            do_press(rs[i], cs[i]);
            do_release(rs[i], cs[i]);
        end
    endtask

    task automatic test_random_keys();
        for (int i = 0; i < 6; i++) begin
            int r;
            int c;
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            repeat ($urandom_range(0, 7)) tick();
            do_press(r, c);
            repeat ($urandom_range(0, 20)) tick();
            do_release(r, c);
        end
    endtask

    task automatic test_bounce();
        int kv0;
        wait_col(3);
        wait_col(0);
        wait_stb();
        kv0 = kv_count;
        force_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) force_row = ~4'($urandom_range(1, 15));
            else            force_row = 4'hF;
            if (i > 0) begin
                checks++;
                if (kif.key_held !== 1'b0) begin
                    failures++;
                    $display("FAIL bounce_held i=%0d: got %b, want 0", i, kif.key_held);
                end
            end
            wait_stb();
        end
        force_en = 1'b0;
        force_row = 4'hF;
        checks++;
        if (kv_count != kv0 || kif.hex !== last_hex || kif.key_held !== 1'b0) begin
            failures++;
            $display("FAIL bounce_result: pulses=%0d hex=%h held=%b, want 0 %h 0", kv_count - kv0, kif.hex, kif.key_held, last_hex);
        end
        checks++;
        if (kif.col !== colv(1 + 5)) begin
            failures++;
            $display("FAIL bounce_col: got %b, want %b", kif.col, colv(6));
        end
    endtask

    task automatic test_two_keys();
        int n;
        int kv0;
        wait_col(3);
        pressed[1 * 4 + 2] = 1'b1;
        pressed[3 * 4 + 2] = 1'b1;
        n = 0;
        while (kif.key_valid !== 1'b1 && n < 100) begin tick(); n++; end
        checks++;
        if (n >= 100 || kif.hex !== 4'h6) begin
            failures++;
            $display("FAIL two_rows_hex: got %h after %0d cycles, want 6", kif.hex, n);
        end
        wait_stb();
        pressed = '0;
        n = 0;
        while (kif.key_held === 1'b1 && n < 100) begin tick(); n++; end
        do_press(1, 1);
        kv0 = kv_count;
        pressed[0 * 4 + 2] = 1'b1;
        repeat (40) tick();
        checks++;
        if (kv_count != kv0 || kif.hex !== 4'h5 || kif.col !== colv(1)) begin
            failures++;
            $display("FAIL two_cols_masked: pulses=%0d hex=%h col=%b, want 0 5 %b", kv_count - kv0, kif.hex, kif.col, colv(1));
        end
        do_release(1, 1);
        n = 0;
        while (kif.key_valid !== 1'b1 && n < 100) begin tick(); n++; end
        checks++;
        if (n >= 100 || kif.hex !== 4'h3) begin
            failures++;
            $display("FAIL two_cols_after: got %h after %0d cycles, want 3", kif.hex, n);
        end
        last_hex = 4'h3;
        do_release(0, 2);
    endtask

    task automatic test_release_bounce();
        int r;
        int c;
        int kv0;
        int drops;
        r = $urandom_range(0, 3);
        c = $urandom_range(0, 3);
        do_press(r, c);
        kv0 = kv_count;
        wait_stb();
        pressed[r * 4 + c] = 1'b0;
        wait_stb();
        wait_stb();
        pressed[r * 4 + c] = 1'b1;
        drops = 0;
        for (int i = 0; i < 6 * SD; i++) begin
            if (kif.key_held !== 1'b1) drops++;
            tick();
        end
        checks++;
        if (drops != 0 || kv_count != kv0 || kif.col !== colv(c)) begin
            failures++;
            $display("FAIL release_bounce: held_low_cycles=%0d pulses=%0d col=%b, want 0 0 %b", drops, kv_count - kv0, kif.col, colv(c));
        end
        do_release(r, c);
    endtask

    task automatic test_reset_mid_press();
        int r;
        int c;
        int n;
        r = $urandom_range(0, 3);
        c = $urandom_range(0, 3);
        do_press(r, c);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (kif.col !== 4'b1110 || kif.hex !== 4'h0 || kif.key_valid !== 1'b0 || kif.key_held !== 1'b0) begin
            failures++;
            $display("FAIL reset_press: col=%b hex=%h kv=%b held=%b, want 1110 0 0 0", kif.col, kif.hex, kif.key_valid, kif.key_held);
        end
        tick();
        rst_n = 1'b1;
        n = 0;
        while (kif.key_valid !== 1'b1 && n < 200) begin tick(); n++; end
        checks++;
        if (n >= 200 || kif.hex !== keymap[r * 4 + c]) begin
            failures++;
            $display("FAIL reset_redetect: got %h after %0d cycles, want %h", kif.hex, n, keymap[r * 4 + c]);
        end
        last_hex = keymap[r * 4 + c];
        do_release(r, c);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_map_corners();
        test_bounce();
        test_two_keys();
        test_release_bounce();
        test_random_keys();
        test_reset_mid_press();
        tick();
        checks++;
        if (kv_wide != 0) begin
            failures++;
            $display("FAIL valid_width: %0d multi-cycle pulses, want 0", kv_wide);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low matrix keypad, debounces one key at a time, and emits its 4-bit hex code with a one-cycle valid strobe. Sits in front of the hex-to-seven-segment display path: its `hex` output feeds the display decoder and game logic directly. Only one key is reported per press. Auto-repeat is not supported.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each column is driven. Must be ≥ 4.
- `DEBOUNCE_SCANS`, default 8: consecutive agreeing samples required to accept a press or a release. Must be ≥ 1.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `row`  in  4  keypad rows, active low, externally pulled up; asynchronous to `clk`.
- `col`  out  4  keypad column drive, active low, exactly one bit low at all times.
- `hex`  out  4  code of the last accepted key; holds between presses.
- `key_valid`  out  1  one-cycle pulse when `hex` is updated.
- `key_held`  out  1  high from acceptance until the release is debounced.

## Operation
- Key map, indexed as row r (0 = top) and column c (0 = left):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D (`*`=E, `#`=F)
- Synchronizer: `row` passes through a 2-flop synchronizer to produce `row_s`.
- Column timing:
  - Divider `div` counts 0..SCAN_DIV-1 and wraps.
  - Sample strobe `stb` fires when `div`==SCAN_DIV-1.
  - `col_idx` (0..3) advances on `stb` only in SCAN state, wrapping 3→0.
  - `col` = ~(1<<col_idx).
- Row select: at `stb`, the candidate is the lowest-index low bit of `row_s`. If 2+ rows are low, the lowest row wins.
- FSM states:
  - SCAN: at `stb`, if any row is low, latch the candidate code, freeze `col_idx`, set cnt=1, and go to DEBOUNCE. If DEBOUNCE_SCANS==1, accept immediately instead.
  - DEBOUNCE: at `stb`:
    - Same row still low: cnt++. When cnt==DEBOUNCE_SCANS, load `hex`, pulse `key_valid`, and go to HELD.
    - Otherwise: go to SCAN, with the column resuming advance on that same `stb`.
  - HELD: `key_held`=1 and `col_idx` stays frozen. At `stb`, if the latched row is high, set cnt=1 and go to RELEASE; otherwise stay.
  - RELEASE: `key_held` stays 1. At `stb`:
    - Latched row high: cnt++. When cnt==DEBOUNCE_SCANS, go to SCAN and drop `key_held`.
    - Latched row low again: go back to HELD without a new `key_valid`.
- Keys in other columns are invisible while the column is frozen. Other rows in the frozen column are ignored in HELD and RELEASE.
- cnt width is clog2(DEBOUNCE_SCANS+1) and it never wraps.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - outputs: `col`=4'b1110, `hex`=0, `key_valid`=0, `key_held`=0
  - internal: state=SCAN, `div`=0, `col_idx`=0, cnt=0, synchronizer flops=4'b1111
- Reset mid-press: the press is discarded. After reset, a still-held key is re-detected from SCAN and reported again.
- Sampling window: each column is sampled once per visit, SCAN_DIV-1 cycles after it is driven. The synchronizer accounts for 2 of those cycles.
- Press latency: `key_valid` and the new `hex` appear one cycle after the `stb` that completes the count. That is at least (DEBOUNCE_SCANS-1)×SCAN_DIV+1 cycles after the first detecting `stb`.
- `key_valid` is exactly one cycle wide. `key_held` rises in the same cycle as `key_valid`.
- Release latency: `key_held` falls one cycle after the DEBOUNCE_SCANS-th consecutive high sample.
- Bounce: any disagreeing sample in DEBOUNCE aborts to SCAN. Any low sample in RELEASE returns to HELD.

## Test plan
Settings for all cases: SCAN_DIV=4, DEBOUNCE_SCANS=3.
- **Reset:** assert `rst_n`=0 mid-scan → `col`=1110, `hex`=0, `key_valid`=0, `key_held`=0 immediately; after release, `col` steps 1110→1101→1011→0111→1110 every 4 cycles.
- **Clean press:** hold row2 low while `col`=1101 (key 8) → `col` freezes at 1101; `hex`=4'h8 with a single `key_valid` pulse 9 cycles after the first detecting `stb`; `key_held`=1. Release → `key_held`=0 after 3 high samples, then scanning resumes.
- **Bounce:** row toggles on alternate strobes for 10 strobes → no `key_valid`, `hex` unchanged, returns to SCAN each time.
- **Map corners:** press r0c0, r0c3, r3c0, r3c1, r3c2, r3c3 in turn → `hex`=1, A, E, 0, F, D.
- **Two keys:** rows 1 and 3 both low in column 2 → `hex`=6. Pressing key 3 (column 2) while holding 5 (column 1) → no new `key_valid` until 5 is released.
- **Release bounce:** in RELEASE, one low sample after 2 highs → back to HELD with `key_held`=1 and no extra `key_valid`.
